// File: rtl/mhp_buf.sv
// Ethernet payload buffer: drains one RX frame into a DEPTH-word buffer, then
// replays it to TX as echo, reverse, increment or drop.
module mhp_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int LEN_W  = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_mode,
    output logic              o_busy,
    output logic              o_done,
    output logic [LEN_W-1:0]  o_len,
    output logic              o_ovf,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic              i_rready,
    output logic              o_rreq,
    output logic [DATA_W-1:0] o_wdata,
    input  logic              i_wready,
    output logic              o_wvalid,
    output logic [1:0]        o_state
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] MODE_ECHO = 2'd0;
    localparam logic [1:0] MODE_REV  = 2'd1;
    localparam logic [1:0] MODE_INC  = 2'd2;
    localparam logic [1:0] MODE_DROP = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // TX handshake: a word moves when o_wvalid && i_wready at a rising edge;
    // o_wvalid/o_wdata hold while i_wready is low. RX side: o_rreq accepted at
    // the edge, i_rdata valid one cycle later (tracked by rd_pend_q).

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                ovf_q, ovf_d;
    logic                rd_pend_q, rd_pend_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wvalid_q, wvalid_d;
    logic                done_q, done_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [AW-1:0]       mem_waddr;

    logic [AW-1:0]       first_addr;
    logic [AW-1:0]       rd_addr;
    logic [DATA_W-1:0]   rd_word;
    logic [DATA_W-1:0]   out_word;

    assign o_rreq    = (state_q == S_READ) && i_rready;
    assign rd_pend_d = o_rreq;
    assign o_busy    = (state_q != S_IDLE);
    assign o_done    = done_q;
    assign o_len     = len_q;
    assign o_ovf     = ovf_q;
    assign o_wdata   = wdata_q;
    assign o_wvalid  = wvalid_q;
    assign o_state   = state_q;

    // Asynchronous buffer read: the first word is fetched on the READ exit
    // cycle and each following word on its predecessor's transfer, so
    // back-to-back transfers need no bubble.
    assign first_addr = (mode_q == MODE_REV) ? AW'(len_q - LEN_W'(1)) : '0;
    assign rd_addr    = (state_q == S_READ) ? first_addr : rd_ptr_q;
    assign rd_word    = mem_q[rd_addr];
    assign out_word   = (mode_q == MODE_INC) ? rd_word + DATA_W'(1) : rd_word;
    assign mem_waddr  = AW'(len_q);

    function automatic logic [AW-1:0] step_ptr(input logic [AW-1:0] p,
                                               input logic [1:0]    m);
        return (m == MODE_REV) ? p - AW'(1) : p + AW'(1);
    endfunction

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        wdata_d  = wdata_q;
        wvalid_d = wvalid_q;
        done_d   = 1'b0;
        mem_we   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_rready) begin
                    mode_d  = i_mode;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (rd_pend_q) begin
                    if (len_q < LEN_W'(DEPTH)) begin
                        mem_we = 1'b1;
                        len_d  = len_q + LEN_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (!i_rready) begin
                    // An empty capture cannot be replayed, so it finishes like a drop.
                    if (mode_q == MODE_DROP || len_q == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = S_WRITE;
                        wdata_d  = out_word;
                        wvalid_d = 1'b1;
                        rd_ptr_d = step_ptr(first_addr, mode_q);
                        cnt_d    = len_q;
                    end
                end
            end
            S_WRITE: begin
                if (wvalid_q && i_wready) begin
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        wvalid_d = 1'b0;
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                    end else begin
                        wdata_d  = out_word;
                        rd_ptr_d = step_ptr(rd_ptr_q, mode_q);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= 2'd0;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            wdata_q   <= '0;
            wvalid_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            len_q     <= len_d;
            ovf_q     <= ovf_d;
            rd_pend_q <= rd_pend_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            wdata_q   <= wdata_d;
            wvalid_q  <= wvalid_d;
            done_q    <= done_d;
        end
    end

    // Buffer contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= i_rdata;
        end
    end

endmodule

// File: tb/tb_mhp_buf.sv
// Randomised scoreboard bench for mhp_buf: a FIFO model feeds frames, a
// frame-level reference predicts TX words, length and overflow.
module tb_mhp_buf;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int LEN_W  = $clog2(DEPTH + 1);

    logic              clk;
    logic              i_rst_n;
    logic [1:0]        i_mode;
    logic              o_busy;
    logic              o_done;
    logic [LEN_W-1:0]  o_len;
    logic              o_ovf;
    logic [DATA_W-1:0] i_rdata;
    logic              i_rready;
    logic              o_rreq;
    logic [DATA_W-1:0] o_wdata;
    logic              i_wready;
    logic              o_wvalid;
    logic [1:0]        o_state;

    mhp_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .i_clk    (clk),
        .i_rst_n  (i_rst_n),
        .i_mode   (i_mode),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_len    (o_len),
        .o_ovf    (o_ovf),
        .i_rdata  (i_rdata),
        .i_rready (i_rready),
        .o_rreq   (o_rreq),
        .o_wdata  (o_wdata),
        .i_wready (i_wready),
        .o_wvalid (o_wvalid),
        .o_state  (o_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [DATA_W-1:0] rx_q[$];
    logic [DATA_W-1:0] frame_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [LEN_W-1:0]  exp_len_q[$];
    logic              exp_ovf_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int xfer_cnt = 0;
    int wr_pat = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: keep the first DEPTH words, then order/transform.
    task automatic issue(input logic [1:0] mode);
        int n;
        int kept;
        logic [DATA_W-1:0] w;
        n = frame_q.size();
        kept = (n > DEPTH) ? DEPTH : n;
        for (int i = 0; i < kept; i++) begin
            case (mode)
                2'd0: exp_q.push_back(frame_q[i]);
                2'd1: exp_q.push_back(frame_q[kept-1-i]);
                2'd2: begin
                    w = frame_q[i] + 8'd1;
                    exp_q.push_back(w);
                end
                default: ;
            endcase
        end
        exp_len_q.push_back(LEN_W'(kept));
        exp_ovf_q.push_back(n > DEPTH);
        for (int i = 0; i < n; i++) rx_q.push_back(frame_q[i]);
    endtask

    // ---------------- drivers ----------------
    // RX FIFO model: request seen before the edge pops one word after it.
    initial begin : fifo_drv
        logic acc;
        i_rready = 1'b0;
        i_rdata  = '0;
        forever begin
            @(negedge clk);
            acc = o_rreq && i_rst_n;
            @(posedge clk);
            #1;
            if (acc && rx_q.size() > 0) i_rdata = rx_q.pop_front();
            i_rready = (rx_q.size() > 0);
        end
    end

    initial begin : wready_drv
        i_wready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (wr_pat)
                0: i_wready = 1'b1;
                1: i_wready = !i_wready;
                default: i_wready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic prev_stall = 1'b0;
        logic prev_xfer = 1'b0;
        logic prev_done = 1'b0;
        logic [DATA_W-1:0] prev_data = '0;
        forever begin
            @(negedge clk);
            if (!i_rst_n) begin
                prev_stall = 1'b0;
                prev_xfer  = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (o_rreq) check("rreq_gated", 32'(i_rready), 32'd1);
                if (prev_stall) begin
                    check("stall_valid", 32'(o_wvalid), 32'd1);
                    check("stall_data", 32'(o_wdata), 32'(prev_data));
                end
                if (prev_xfer && wr_pat == 0 && exp_q.size() > 0)
                    check("no_bubble", 32'(o_wvalid), 32'd1);
                if (o_wvalid && i_wready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_word: got 0x%0h expected none at %0t", o_wdata, $time);
                    end else begin
                        check("wdata", 32'(o_wdata), 32'(exp_q.pop_front()));
                    end
                    xfer_cnt++;
                end
                if (o_done) begin
                    check("done_width", 32'(prev_done), 32'd0);
                    if (exp_len_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_done: got 1 expected 0 at %0t", $time);
                    end else begin
                        check("len", 32'(o_len), 32'(exp_len_q.pop_front()));
                        check("ovf", 32'(o_ovf), 32'(exp_ovf_q.pop_front()));
                    end
                    check("words_left", 32'(exp_q.size()), 32'd0);
                    check("fifo_drained", 32'(rx_q.size()), 32'd0);
                    check("wvalid_at_done", 32'(o_wvalid), 32'd0);
                    done_cnt++;
                end
                prev_stall = o_wvalid && !i_wready;
                prev_xfer  = o_wvalid && i_wready;
                prev_done  = o_done;
                prev_data  = o_wdata;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_frame(input logic [1:0] mode, input int pat);
        int start;
        bit seen;
        wr_pat = pat;
        @(negedge clk);
        i_mode = mode;
        issue(mode);
        start = done_cnt;
        repeat (3) @(negedge clk);
        i_mode = 2'($urandom_range(0, 3));
        seen = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (done_cnt != start) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got no o_done expected one within 3000 cycles");
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin : main
        int start_x;
        int n;
        i_rst_n = 1'b0;
        i_mode  = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_len", 32'(o_len), 32'd0);
        check("rst_ovf", 32'(o_ovf), 32'd0);
        check("rst_wvalid", 32'(o_wvalid), 32'd0);
        check("rst_wdata", 32'(o_wdata), 32'd0);
        check("rst_rreq", 32'(o_rreq), 32'd0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge clk);

        frame_q = '{8'h11, 8'h22, 8'h33};
        send_frame(2'd0, 0);
        frame_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        send_frame(2'd1, 1);
        frame_q = '{8'hFE, 8'hFF, 8'h00};
        send_frame(2'd2, 0);

        frame_q.delete();
        for (int i = 1; i <= DEPTH + 2; i++) frame_q.push_back(DATA_W'(i));
        send_frame(2'd0, 0);
        check("ovf_held", 32'(o_ovf), 32'd1);
        check("len_sat_held", 32'(o_len), 32'(DEPTH));

        frame_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_frame(2'd3, 0);
        frame_q = '{8'h5A};
        send_frame(2'd0, 0);
        check("len_held", 32'(o_len), 32'd1);
        check("ovf_clear", 32'(o_ovf), 32'd0);

        for (int f = 0; f < 30; f++) begin
            frame_q.delete();
            n = $urandom_range(1, DEPTH + 4);
            for (int i = 0; i < n; i++) frame_q.push_back(DATA_W'($urandom));
            send_frame(2'($urandom_range(0, 3)), $urandom_range(0, 2));
        end

        // Asynchronous reset in the middle of a replay.
        wr_pat = 0;
        @(negedge clk);
        i_mode = 2'd0;
        frame_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        issue(2'd0);
        start_x = xfer_cnt;
        for (int k = 0; k < 200; k++) begin
            if (xfer_cnt - start_x >= 2) break;
            @(negedge clk);
        end
        check("pre_reset_xfers", 32'(xfer_cnt - start_x), 32'd2);
        @(posedge clk);
        #3;
        check("pre_reset_wvalid", 32'(o_wvalid), 32'd1);
        i_rst_n = 1'b0;
        #1;
        check("async_wvalid", 32'(o_wvalid), 32'd0);
        check("async_busy", 32'(o_busy), 32'd0);
        check("async_done", 32'(o_done), 32'd0);
        exp_q.delete();
        exp_len_q.delete();
        exp_ovf_q.delete();
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        repeat (2) @(negedge clk);

        frame_q = '{8'h3C, 8'hC3};
        send_frame(2'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mhp_buf.md
Name: mhp_buf

Overview:
- Parametrised successor to the single-byte Ethernet payload handler.
- Drains a complete received payload from the RX FIFO into an internal buffer of DEPTH words, then replays it to the TX interface under a selectable mode: echo, reverse, increment or drop.
- Sits between the Ethernet RX/TX FIFOs and the control logic, with the same read-request and write-valid/ready conventions.

Parameters:
DATA_W, 8, width of payload words on i_rdata/o_wdata
DEPTH, 64, buffer capacity in words; must be a power of 2, at least 2
LEN_W, $clog2(DEPTH+1), width of o_len

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_mode  input  2  0 echo, 1 reverse, 2 increment, 3 drop; sampled at frame start
o_busy  output  1  high whenever state != IDLE
o_done  output  1  one-cycle pulse when frame handling completes
o_len  output  LEN_W  words stored for last/current frame, saturates at DEPTH
o_ovf  output  1  frame exceeded DEPTH; held until next frame start
i_rdata  input  DATA_W  RX FIFO data, valid the cycle after an accepted o_rreq
i_rready  input  1  RX FIFO non-empty
o_rreq  output  1  RX FIFO read request
o_wdata  output  DATA_W  TX data
i_wready  input  1  TX FIFO can accept
o_wvalid  output  1  TX data valid

Behaviour:
- Reset (async, i_rst_n low): state=IDLE, o_rreq=0, o_wvalid=0, o_wdata=0, o_done=0, o_busy=0, o_len=0, o_ovf=0, internal pointers and pending flag 0. Buffer RAM is not cleared.
- Reset mid-frame aborts immediately. The partially read frame is lost, and the RX FIFO remainder is treated as a new frame after reset.
- o_rreq = (state==READ) && i_rready, combinational. Never asserted with i_rready low.
- rd_pend is a register set to o_rreq. When rd_pend=1, i_rdata is captured that cycle.
- States:
  - IDLE: if i_rready, latch i_mode into mode_q, clear o_len/o_ovf/wr_ptr, go to READ.
  - READ: each captured word is written at buf[wr_ptr] if wr_ptr<DEPTH, and wr_ptr/o_len increment. Otherwise the word is discarded and o_ovf is set; the FIFO is still drained. Exit when !i_rready && !rd_pend: go to DONE if mode_q==3, else WRITE with rd_ptr = (mode_q==1) ? o_len-1 : 0 and cnt=o_len.
  - WRITE: present buf[rd_ptr] on o_wdata with o_wvalid=1. In mode 2 the word is buf[rd_ptr]+1 modulo 2^DATA_W.
    - A transfer occurs when o_wvalid && i_wready. On transfer, rd_ptr steps (+1, or -1 for reverse) and cnt decrements.
    - o_wdata/o_wvalid hold stable while i_wready is low.
    - After the transfer with cnt==1, drop o_wvalid and go to DONE. At most one word per cycle, back-to-back when i_wready stays high.
  - DONE: o_done=1 for exactly one cycle, then IDLE.
- The RAM read may be registered. If so, prefetch the next word so that back-to-back transfers sustain one word per clock; no bubbles are allowed while i_wready=1.
- New RX data arriving during WRITE/DONE is not read; o_rreq stays 0. IDLE re-arms one cycle after DONE.
- Minimum frame length is 1; frames are defined as contiguous i_rready-high runs seen while in READ.
- o_len and o_ovf remain valid after o_done until the next frame start.
- Latency: the first o_wvalid appears at most 2 cycles after the READ exit condition.

Test Plan:
- Echo: mode 0, FIFO holds 0x11,0x22,0x33 → o_rreq high for 3 cycles; output 0x11,0x22,0x33 with i_wready=1 on consecutive cycles; o_len=3; o_done pulses once; o_ovf=0.
- Reverse + backpressure: mode 1, payload 0xA0..0xA4, i_wready toggling 1,0,1,0 → output 0xA4,0xA3,0xA2,0xA1,0xA0; o_wdata stable on every stalled cycle.
- Increment wrap: mode 2, payload 0xFE,0xFF,0x00 → output 0xFF,0x00,0x01.
- Overflow: DEPTH=4, mode 0, 6-byte payload 1..6 → 6 reads issued, FIFO empty afterwards; output 1,2,3,4; o_len=4; o_ovf=1 until next frame start.
- Drop: mode 3, 5 bytes → FIFO drained, o_wvalid never asserted, o_done one pulse, o_len=5. Then a 1-byte echo frame 0x5A → single output 0x5A.
- Async reset mid-WRITE: pull i_rst_n low after 2 of 4 words transferred → o_wvalid, o_busy, o_done drop without a clock edge. After release, a new 2-byte frame echoes correctly.
